// File: rtl/fp_cmp_pipe.sv
// -----------------------------------------------------------------------------
// fp_cmp_pipe
//   Pipelined floating-point compare / min / max unit for the FPU execute
//   stage. Operands are classified internally (zero, NaN, signalling NaN), the
//   operation is evaluated combinationally on the way in, and the outcome is
//   carried through STAGES register slots behind a valid/ready handshake.
//   Throughput is one op per cycle; latency is exactly STAGES when unstalled.
//
//   Ops: 0 fle, 1 flt, 2 feq, 3 fmin, 4 fmax; 5..7 reserved (result 0, no flags).
//   NaN / signed-zero handling follows the RISC-V rules:
//     - feq raises NV only on sNaN; flt/fle raise NV on any NaN.
//     - fmin/fmax raise NV on sNaN, return the non-NaN operand when exactly one
//       is NaN, the canonical qNaN when both are, and order -0 below +0.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-high; flushes all in-flight ops
//   in_valid   in   1   operands and op valid this cycle
//   in_ready   out  1   unit accepts an op this cycle (combinational)
//   data1      in   W   operand A: sign | exp | mant
//   data2      in   W   operand B
//   op         in   3   operation select
//   out_valid  out  1   result and flags valid (registered)
//   out_ready  in   1   consumer accepts result
//   result     out  W   compare: bit0 = outcome; fmin/fmax: selected value
//   flags      out  5   {NV,DZ,OF,UF,NX}; only NV can be set
// -----------------------------------------------------------------------------
module fp_cmp_pipe #(
  parameter  int EXP_W  = 11,
  parameter  int MANT_W = 52,
  parameter  int STAGES = 2,
  localparam int W      = 1 + EXP_W + MANT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data1,
  input  logic [W-1:0] data2,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [4:0]   flags
);

  typedef enum logic [2:0] {
    OP_FLE  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FEQ  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } op_e;

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic [W-2:0]      mag_a, mag_b;
  logic              nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;

  assign sign_a = data1[W-1];
  assign sign_b = data2[W-1];
  assign exp_a  = data1[W-2 -: EXP_W];
  assign exp_b  = data2[W-2 -: EXP_W];
  assign mant_a = data1[MANT_W-1:0];
  assign mant_b = data2[MANT_W-1:0];
  assign mag_a  = data1[W-2:0];
  assign mag_b  = data2[W-2:0];

  assign nan_a  = (&exp_a) & (|mant_a);
  assign nan_b  = (&exp_b) & (|mant_b);
  assign snan_a = nan_a & ~mant_a[MANT_W-1];
  assign snan_b = nan_b & ~mant_b[MANT_W-1];
  assign zero_a = ~|mag_a;
  assign zero_b = ~|mag_b;

  // ---------------------------------------------------------------------------
  // Ordering. lt_total is a total order on non-NaN values with -0 < +0, which
  // is exactly what fmin/fmax need. The compare ops reuse it but treat the two
  // zeros as equal.
  // ---------------------------------------------------------------------------
  logic both_zero, nan_any, snan_any;
  logic lt_total, lt_cmp, eq_cmp;

  assign both_zero = zero_a & zero_b;
  assign nan_any   = nan_a | nan_b;
  assign snan_any  = snan_a | snan_b;

  always_comb begin
    if (sign_a != sign_b) begin
      lt_total = sign_a;
    end else if (sign_a) begin
      lt_total = mag_a > mag_b;   // both negative: larger magnitude is smaller
    end else begin
      lt_total = mag_a < mag_b;
    end
  end

  assign lt_cmp = lt_total & ~both_zero;
  assign eq_cmp = both_zero | (data1 == data2);

  // ---------------------------------------------------------------------------
  // Operation evaluation
  // ---------------------------------------------------------------------------
  logic [W-1:0] calc_result;
  logic         calc_nv;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    calc_result = '0;
    calc_nv     = 1'b0;
    case (op_e'(op))
      OP_FEQ: begin
        calc_nv     = snan_any;
        calc_result = W'(~nan_any & eq_cmp);
      end
      OP_FLT: begin
        calc_nv     = nan_any;
        calc_result = W'(~nan_any & lt_cmp);
      end
      OP_FLE: begin
        calc_nv     = nan_any;
        calc_result = W'(~nan_any & (lt_cmp | eq_cmp));
      end
      OP_FMIN, OP_FMAX: begin
        calc_nv = snan_any;
        if (nan_a & nan_b) begin
          calc_result = CANON_NAN;
        end else if (nan_a) begin
          calc_result = data2;
        end else if (nan_b) begin
          calc_result = data1;
        end else if ((op_e'(op) == OP_FMIN) == lt_total) begin
          calc_result = data1;
        end else begin
          calc_result = data2;
        end
      end
      default: begin
        calc_result = '0;
        calc_nv     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline. All slots shift together on advance; bubbles travel as slots
  // with valid = 0 and zeroed payload so an idle output reads as 0.
  // ---------------------------------------------------------------------------
  logic         stg_valid  [STAGES];
  logic [W-1:0] stg_result [STAGES];
  logic         stg_nv     [STAGES];
  logic         advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // NOTE: the payload registers are reset along with the valid bits because
  // the last slot drives result/flags directly and must read 0 after reset;
  // all state updates use non-blocking assignments so slots shift in lockstep.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_valid[i]  <= 1'b0;
        stg_result[i] <= '0;
        stg_nv[i]     <= 1'b0;
      end
    end else if (advance) begin
      stg_valid[0]  <= in_valid;
      stg_result[0] <= in_valid ? calc_result : '0;
      stg_nv[0]     <= in_valid & calc_nv;
      for (int i = 1; i < STAGES; i++) begin
        stg_valid[i]  <= stg_valid[i-1];
        stg_result[i] <= stg_result[i-1];
        stg_nv[i]     <= stg_nv[i-1];
      end
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign result    = stg_result[STAGES-1];
  assign flags     = {stg_nv[STAGES-1], 4'b0000};

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_cmp_pipe
//   Self-checking bench for fp_cmp_pipe. A double-precision, 2-stage instance
//   is driven through directed vectors, a stall sequence, a mid-flight reset
//   and a randomized stream scored against a real-arithmetic reference model.
//   Two single-precision instances (1 and 4 stages) replay the directed
//   vectors and have their latency measured.
// -----------------------------------------------------------------------------
module tb_fp_cmp_pipe;

  localparam logic [2:0] FLE = 3'd0, FLT = 3'd1, FEQ = 3'd2, FMIN = 3'd3, FMAX = 3'd4;
  localparam logic [4:0] NV  = 5'b10000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // double-precision DUT
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data1 = '0, data2 = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic [4:0]  flags;

  // single-precision DUTs share their inputs
  logic        sp_in_valid = 1'b0;
  logic [31:0] sp_data1 = '0, sp_data2 = '0;
  logic [2:0]  sp_op = '0;
  logic        sp_out_ready = 1'b1;
  logic        sp1_in_ready, sp1_out_valid, sp4_in_ready, sp4_out_valid;
  logic [31:0] sp1_result, sp4_result;
  logic [4:0]  sp1_flags, sp4_flags;

  always #5 clock = ~clock;

  fp_cmp_pipe #(.EXP_W(11), .MANT_W(52), .STAGES(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_cmp_pipe #(.EXP_W(8), .MANT_W(23), .STAGES(1)) dut_sp1 (
    .clock(clock), .reset(reset), .in_valid(sp_in_valid), .in_ready(sp1_in_ready),
    .data1(sp_data1), .data2(sp_data2), .op(sp_op), .out_valid(sp1_out_valid),
    .out_ready(sp_out_ready), .result(sp1_result), .flags(sp1_flags)
  );

  fp_cmp_pipe #(.EXP_W(8), .MANT_W(23), .STAGES(4)) dut_sp4 (
    .clock(clock), .reset(reset), .in_valid(sp_in_valid), .in_ready(sp4_in_ready),
    .data1(sp_data1), .data2(sp_data2), .op(sp_op), .out_valid(sp4_out_valid),
    .out_ready(sp_out_ready), .result(sp4_result), .flags(sp4_flags)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] r;
    logic [4:0]  f;
  } exp_t;

  int checks = 0;
  int passes = 0;

  vec_t src_q[$];
  exp_t exp_q[$];

  string       cur_name;
  logic [63:0] cur_r;
  logic [4:0]  cur_f;

  bit          hold_pending = 0;
  logic [63:0] held_r;
  logic [4:0]  held_f;
  bit          last_out_valid;
  bit          last_in_ready;
  bit          saw_backpressure = 0;
  int          n_out = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] o, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] r, input logic [4:0] f);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b; v.r = r; v.f = f;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: classification by bit pattern, ordering by real numbers.
  // ---------------------------------------------------------------------------
  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic bit is_snan(input logic [63:0] x);
    return is_nan(x) && !x[51];
  endfunction

  function automatic void ref_model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [4:0] f);
    real ra, rb;
    bit  any_nan, any_snan;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    any_nan  = is_nan(a) || is_nan(b);
    any_snan = is_snan(a) || is_snan(b);
    r = '0;
    f = '0;
    case (o)
      FLE: begin f = any_nan ? NV : 5'd0; r = 64'(!any_nan && (ra <= rb)); end
      FLT: begin f = any_nan ? NV : 5'd0; r = 64'(!any_nan && (ra <  rb)); end
      FEQ: begin f = any_snan ? NV : 5'd0; r = 64'(!any_nan && (ra == rb)); end
      FMIN, FMAX: begin
        f = any_snan ? NV : 5'd0;
        if (is_nan(a) && is_nan(b)) r = 64'h7FF8_0000_0000_0000;
        else if (is_nan(a))         r = b;
        else if (is_nan(b))         r = a;
        else if (ra < rb)           r = (o == FMIN) ? a : b;
        else if (rb < ra)           r = (o == FMIN) ? b : a;
        else                        r = ((o == FMIN) == a[63]) ? a : b; // equal: only +/-0 differ
      end
      default: begin r = '0; f = '0; end
    endcase
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: x = {x[63], 63'd0};
      1: x = {x[63], 11'h7FF, 1'b1, x[50:0]};
      2: x = {x[63], 11'h7FF, 1'b0, x[50:1], 1'b1};
      3: x = {x[63], 11'h7FF, 52'd0};
      4: x = {x[63], 11'h3FF, 50'd0, x[1:0]};
      5: x = {x[63], 11'd0, x[51:0]};
      default: ;
    endcase
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // One clock of the double-precision DUT: observe at the falling edge,
  // then let the rising edge happen and return just after it.
  // ---------------------------------------------------------------------------
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clock);
    if (!reset && hold_pending) begin
      check("held out_valid", 64'(out_valid), 64'd1);
      check("held result", result, held_r);
      check("held flags", 64'(flags), 64'(held_f));
    end
    hold_pending = !reset && out_valid && !out_ready;
    held_r = result;
    held_f = flags;
    check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (in_valid && !in_ready) saw_backpressure = 1;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected output: got result %h, expected no output", result);
      end else begin
        e = exp_q.pop_front();
        check({e.name, " result"}, result, e.r);
        check({e.name, " flags"}, 64'(flags), 64'(e.f));
        n_out++;
      end
    end
    acc = !reset && in_valid && in_ready;
    if (acc) exp_q.push_back('{cur_name, cur_r, cur_f});
    last_out_valid = out_valid;
    last_in_ready  = in_ready;
    @(posedge clock);
    #1;
    if (reset) begin
      exp_q.delete();
      hold_pending = 0;
    end
  endtask

  // Drives src_q into the DUT until everything is sent and drained.
  task automatic drive_stream(input int stall_from, input int stall_len, input bit rand_mode);
    int cyc = 0;
    bit acc;
    bit holding = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (src_q.size() > 0 && (holding || !rand_mode || $urandom_range(0, 3) != 0)) begin
        op = src_q[0].op; data1 = src_q[0].a; data2 = src_q[0].b;
        cur_name = src_q[0].name; cur_r = src_q[0].r; cur_f = src_q[0].f;
        in_valid = 1'b1;
        holding  = 1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (acc) begin
        src_q.delete(0);
        holding = 0;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 3000) begin
      checks++;
      $display("FAIL stream timeout: got %0d results outstanding, expected 0", exp_q.size());
      src_q.delete();
      exp_q.delete();
    end
  endtask

  // Single op through both single-precision instances with latency measurement.
  task automatic run_sp(input vec_t v);
    int lat1 = 0;
    int lat4 = 0;
    sp_op = v.op; sp_data1 = v.a[31:0]; sp_data2 = v.b[31:0];
    sp_in_valid = 1'b1;
    @(negedge clock);
    check({v.name, " sp in_ready"}, 64'(sp1_in_ready & sp4_in_ready), 64'd1);
    @(posedge clock);
    #1;
    sp_in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (sp1_out_valid && lat1 == 0) begin
        lat1 = k;
        check({v.name, " sp1 result"}, 64'(sp1_result), 64'(v.r[31:0]));
        check({v.name, " sp1 flags"}, 64'(sp1_flags), 64'(v.f));
      end
      if (sp4_out_valid && lat4 == 0) begin
        lat4 = k;
        check({v.name, " sp4 result"}, 64'(sp4_result), 64'(v.r[31:0]));
        check({v.name, " sp4 flags"}, 64'(sp4_flags), 64'(v.f));
      end
    end
    @(posedge clock);
    #1;
    check({v.name, " sp1 latency"}, 64'(lat1), 64'd1);
    check({v.name, " sp4 latency"}, 64'(lat4), 64'd4);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  localparam logic [63:0] D_ONE = 64'h3FF0_0000_0000_0000, D_TWO = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_M1  = 64'hBFF0_0000_0000_0000, D_M2  = 64'hC000_0000_0000_0000;
  localparam logic [63:0] D_PZ  = 64'h0, D_NZ = 64'h8000_0000_0000_0000;
  localparam logic [63:0] D_QN  = 64'h7FF8_0000_0000_0000, D_SN = 64'h7FF0_0000_0000_0001;

  initial begin
    vec_t tbl[$];
    vec_t sp_tbl[$];
    vec_t v;
    bit   acc;
    int   lat;
    int   n0;
    logic [63:0] ra, rb, rr;
    logic [4:0]  rf;
    logic [2:0]  ro;

    tbl.push_back(mk("flt 1<2",        FLT,  D_ONE, D_TWO, 64'd1, 5'd0));
    tbl.push_back(mk("feq +0 -0",      FEQ,  D_PZ,  D_NZ,  64'd1, 5'd0));
    tbl.push_back(mk("fmin +0 -0",     FMIN, D_PZ,  D_NZ,  D_NZ,  5'd0));
    tbl.push_back(mk("fmax +0 -0",     FMAX, D_PZ,  D_NZ,  D_PZ,  5'd0));
    tbl.push_back(mk("feq qnan 1",     FEQ,  D_QN,  D_ONE, 64'd0, 5'd0));
    tbl.push_back(mk("flt qnan 1",     FLT,  D_QN,  D_ONE, 64'd0, NV));
    tbl.push_back(mk("fmax snan 2",    FMAX, D_SN,  D_TWO, D_TWO, NV));
    tbl.push_back(mk("fmin snan qnan", FMIN, D_SN,  D_QN,  D_QN,  NV));
    tbl.push_back(mk("fle 2<=2",       FLE,  D_TWO, D_TWO, 64'd1, 5'd0));
    tbl.push_back(mk("flt -1<1",       FLT,  D_M1,  D_ONE, 64'd1, 5'd0));
    tbl.push_back(mk("flt +0<-0",      FLT,  D_PZ,  D_NZ,  64'd0, 5'd0));
    tbl.push_back(mk("fle -0<=+0",     FLE,  D_NZ,  D_PZ,  64'd1, 5'd0));
    tbl.push_back(mk("fmin -1 -2",     FMIN, D_M1,  D_M2,  D_M2,  5'd0));
    tbl.push_back(mk("fmax -1 -2",     FMAX, D_M1,  D_M2,  D_M1,  5'd0));
    tbl.push_back(mk("fmin qnan qnan", FMIN, D_QN,  D_QN,  D_QN,  5'd0));
    tbl.push_back(mk("reserved op",    3'd5, D_SN,  D_ONE, 64'd0, 5'd0));

    sp_tbl.push_back(mk("sp flt 1<2",        FLT,  64'h3F80_0000, 64'h4000_0000, 64'd1, 5'd0));
    sp_tbl.push_back(mk("sp feq +0 -0",      FEQ,  64'h0,         64'h8000_0000, 64'd1, 5'd0));
    sp_tbl.push_back(mk("sp fmin +0 -0",     FMIN, 64'h0,         64'h8000_0000, 64'h8000_0000, 5'd0));
    sp_tbl.push_back(mk("sp fmax +0 -0",     FMAX, 64'h0,         64'h8000_0000, 64'h0, 5'd0));
    sp_tbl.push_back(mk("sp feq qnan 1",     FEQ,  64'h7FC0_0000, 64'h3F80_0000, 64'd0, 5'd0));
    sp_tbl.push_back(mk("sp flt qnan 1",     FLT,  64'h7FC0_0000, 64'h3F80_0000, 64'd0, NV));
    sp_tbl.push_back(mk("sp fmax snan 2",    FMAX, 64'h7F80_0001, 64'h4000_0000, 64'h4000_0000, NV));
    sp_tbl.push_back(mk("sp fmin snan qnan", FMIN, 64'h7F80_0001, 64'h7FC0_0000, 64'h7FC0_0000, NV));

    // Reset state
    repeat (3) step(acc);
    reset = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);

    // Latency of a lone flt 1.0 < 2.0
    op = FLT; data1 = D_ONE; data2 = D_TWO;
    cur_name = "flt latency op"; cur_r = 64'd1; cur_f = 5'd0;
    in_valid = 1'b1;
    step(acc);
    check("flt accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
    lat = 0;
    do begin
      step(acc);
      lat++;
    end while (!last_out_valid && lat < 20);
    check("flt latency", 64'(lat), 64'd2);

    // Directed vectors, back to back
    foreach (tbl[i]) src_q.push_back(tbl[i]);
    drive_stream(0, 0, 0);

    // Stall of 3 cycles mid-stream
    saw_backpressure = 0;
    n0 = n_out;
    for (int i = 0; i < 6; i++) src_q.push_back(tbl[i]);
    drive_stream(3, 3, 0);
    check("stall in_ready dropped", 64'(saw_backpressure), 64'd1);
    check("stall output count", 64'(n_out - n0), 64'd6);

    // Reset with two ops in flight
    out_ready = 1'b0;
    op = FLT; data1 = D_ONE; data2 = D_TWO;
    cur_name = "flushed op"; cur_r = 64'd1; cur_f = 5'd0;
    in_valid = 1'b1;
    step(acc);
    step(acc);
    in_valid = 1'b0;
    reset = 1'b1;
    step(acc);
    reset = 1'b0;
    step(acc);
    check("flush out_valid", 64'(last_out_valid), 64'd0);
    check("flush in_ready", 64'(last_in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) step(acc);
    src_q.push_back(mk("fle -1<=-2", FLE, D_M1, D_M2, 64'd0, 5'd0));
    drive_stream(0, 0, 0);

    // Randomized stream against the reference model
    for (int i = 0; i < 300; i++) begin
      ra = rand_fp();
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = {~ra[63], ra[62:0]};
        default: rb = rand_fp();
      endcase
      ro = 3'($urandom_range(0, 7));
      ref_model(ro, ra, rb, rr, rf);
      src_q.push_back(mk("random", ro, ra, rb, rr, rf));
    end
    drive_stream(0, 0, 1);

    // Single-precision sweep on 1- and 4-stage instances
    foreach (sp_tbl[i]) begin
      v = sp_tbl[i];
      run_sp(v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
